// File: rtl/key_pkg.sv
// Shared types and elaboration-time parameter checks for the key event classifier.
package key_pkg;

  typedef enum logic [2:0] {
    WAIT_REL = 3'd0,
    IDLE     = 3'd1,
    ARMING   = 3'd2,
    PRESSED  = 3'd3,
    LONG     = 3'd4
  } key_state_t;

  function automatic bit key_timing_ok(input int unsigned min_press,
                                       input int unsigned long_cycles);
    return (min_press >= 32'd1) && (min_press < long_cycles);
  endfunction

  function automatic bit key_repeat_ok(input int unsigned repeat_cycles);
    return repeat_cycles >= 32'd1;
  endfunction

  function automatic int unsigned key_max(input int unsigned a,
                                          input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_event.sv
// Turns a debounced key level into single-cycle press/click/long/repeat/release
// pulses plus a held level; one shared counter times every phase of a press.
module key_event
  import key_pkg::*;
#(
  parameter int unsigned MIN_PRESS     = 500_000,
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic clr_n,
  input  logic key_in,
  output logic press_o,
  output logic click_o,
  output logic long_o,
  output logic repeat_o,
  output logic release_o,
  output logic held_o
);

  // The counter is reused for the repeat period, so size it for whichever is larger.
  localparam int unsigned CW = $clog2(key_max(LONG_CYCLES, REPEAT_CYCLES) + 32'd1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(32'd1);
  localparam logic [CW-1:0] PRESS_LAST = CW'(MIN_PRESS - 32'd1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_CYCLES - 32'd1);
  localparam logic [CW-1:0] REP_LAST   = CW'(REPEAT_CYCLES - 32'd1);

  if (!key_timing_ok(MIN_PRESS, LONG_CYCLES) || !key_repeat_ok(REPEAT_CYCLES)) begin : g_param_check
    $error("key_event: illegal MIN_PRESS/LONG_CYCLES/REPEAT_CYCLES combination");
  end

  key_state_t    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          press_s, click_s, long_s, repeat_s, release_s, held_s;

  // Next-state, counter and event decode; a release always pre-empts long/repeat.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    press_s   = 1'b0;
    click_s   = 1'b0;
    long_s    = 1'b0;
    repeat_s  = 1'b0;
    release_s = 1'b0;
    case (state_r)
      WAIT_REL: begin
        if (!key_in) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_REL;
        end
        cnt_s = '0;
      end
      IDLE: begin
        if (key_in) begin
          cnt_s = CNT_ONE;
          if (MIN_PRESS == 32'd1) begin
            state_s = PRESSED;
            press_s = 1'b1;
          end else begin
            state_s = ARMING;
          end
        end else begin
          cnt_s = '0;
        end
      end
      ARMING: begin
        if (key_in) begin
          cnt_s = cnt_r + CNT_ONE;
          if (cnt_r == PRESS_LAST) begin
            state_s = PRESSED;
            press_s = 1'b1;
          end else begin
            state_s = ARMING;
          end
        end else begin
          state_s = IDLE;
          cnt_s   = '0;
        end
      end
      PRESSED: begin
        if (!key_in) begin
          state_s   = IDLE;
          cnt_s     = '0;
          click_s   = 1'b1;
          release_s = 1'b1;
        end else if (cnt_r == LONG_LAST) begin
          state_s = LONG;
          cnt_s   = '0;
          long_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      LONG: begin
        if (!key_in) begin
          state_s   = IDLE;
          cnt_s     = '0;
          release_s = 1'b1;
        end else if (cnt_r == REP_LAST) begin
          cnt_s    = '0;
          repeat_s = REPEAT_EN;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = WAIT_REL;
        cnt_s   = '0;
      end
    endcase
    held_s = (state_s == PRESSED) || (state_s == LONG);
  end

  // State, counter and registered event outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r   <= WAIT_REL;
      cnt_r     <= '0;
      press_o   <= 1'b0;
      click_o   <= 1'b0;
      long_o    <= 1'b0;
      repeat_o  <= 1'b0;
      release_o <= 1'b0;
      held_o    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      press_o   <= press_s;
      click_o   <= click_s;
      long_o    <= long_s;
      repeat_o  <= repeat_s;
      release_o <= release_s;
      held_o    <= held_s;
    end
  end

endmodule

// File: tb/tb_key_event.sv
// Scoreboard bench for key_event: a run-length reference model predicts every
// output cycle, a monitor compares two DUTs (repeat enabled and disabled).
module tb_key_event;

  localparam int MIN = 4;
  localparam int LNG = 20;
  localparam int REP = 5;
  localparam logic [5:0] REP_MASK = 6'b000100;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic key_in = 1'b0;

  logic a_press, a_click, a_long, a_repeat, a_release, a_held;
  logic b_press, b_click, b_long, b_repeat, b_release, b_held;

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q[$];

  int m_need_low = 1;
  int m_run = 0;

  always #5 clk = ~clk;

  key_event #(.MIN_PRESS(MIN), .LONG_CYCLES(LNG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1)) dut_a (
    .clk(clk), .clr_n(clr_n), .key_in(key_in),
    .press_o(a_press), .click_o(a_click), .long_o(a_long),
    .repeat_o(a_repeat), .release_o(a_release), .held_o(a_held)
  );

  key_event #(.MIN_PRESS(MIN), .LONG_CYCLES(LNG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b0)) dut_b (
    .clk(clk), .clr_n(clr_n), .key_in(key_in),
    .press_o(b_press), .click_o(b_click), .long_o(b_long),
    .repeat_o(b_repeat), .release_o(b_release), .held_o(b_held)
  );

  function automatic logic [5:0] vec_a();
    return {a_press, a_click, a_long, a_repeat, a_release, a_held};
  endfunction

  function automatic logic [5:0] vec_b();
    return {b_press, b_click, b_long, b_repeat, b_release, b_held};
  endfunction

  task automatic compare(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got {press,click,long,repeat,release,held}=%b expected %b",
               name, $time, act, exp);
    end
  endtask

  // Reference: outputs follow from how many consecutive high samples the key has had.
  task automatic model_step(input logic k, output logic [5:0] e);
    logic p, c, l, r, rl, h;
    p = 1'b0; c = 1'b0; l = 1'b0; r = 1'b0; rl = 1'b0; h = 1'b0;
    if (m_need_low != 0) begin
      if (!k) m_need_low = 0;
    end else if (k) begin
      m_run++;
      p = (m_run == MIN);
      l = (m_run == LNG);
      r = (m_run > LNG) && (((m_run - LNG) % REP) == 0);
      h = (m_run >= MIN);
    end else begin
      rl = (m_run >= MIN);
      c  = rl && (m_run < LNG);
      m_run = 0;
    end
    e = {p, c, l, r, rl, h};
  endtask

  task automatic drive(input logic k);
    logic [5:0] e;
    @(negedge clk);
    key_in = k;
    model_step(k, e);
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic k, input int n);
    for (int i = 0; i < n; i++) drive(k);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    compare("reset_a", vec_a(), 6'b000000);
    compare("reset_b", vec_b(), 6'b000000);
    exp_q.delete();
    m_need_low = 1;
    m_run = 0;
    repeat (cycles) @(negedge clk);
    clr_n = 1'b1;
  endtask

  // Monitor: every cycle the DUTs present a registered output word to check.
  always @(posedge clk) begin
    logic [5:0] e;
    #1;
    if (clr_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compare("dut_a", vec_a(), e);
      compare("dut_b", vec_b(), e & ~REP_MASK);
    end
  end

  initial begin
    #2;
    compare("por_a", vec_a(), 6'b000000);
    compare("por_b", vec_b(), 6'b000000);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;

    hold(1'b0, 3);
    hold(1'b1, 3);  hold(1'b0, 3);   // glitch
    hold(1'b1, 10); hold(1'b0, 1);   // short press, single low gap
    hold(1'b1, 4);  hold(1'b0, 2);   // minimum qualifying press
    hold(1'b1, 32); hold(1'b0, 3);   // long press with repeats
    hold(1'b1, 19); hold(1'b0, 2);   // release on the long edge
    hold(1'b1, 29); hold(1'b0, 2);   // release on a repeat edge

    hold(1'b1, 26);                  // into LONG, then reset while held
    do_reset(3);
    hold(1'b1, 6);
    hold(1'b0, 2);
    hold(1'b1, 4);  hold(1'b0, 2);

    do_reset(2);                     // reset with key low
    hold(1'b0, 2);
    for (int s = 0; s < 30; s++) begin
      hold(1'b1, int'($urandom_range(1, 40)));
      hold(1'b0, int'($urandom_range(1, 4)));
    end
    hold(1'b0, 3);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected words never compared, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
